// File: rtl/spi_write_if.sv
// Request/response and SPI wire bundle for spi_write_controller.
// master = requester side, slave = controller side.
interface spi_write_if;
    logic       start;
    logic [6:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic       sclk;
    logic       copi;
    logic       ncs;

    modport master (
        output start, addr, wdata,
        input  busy, done, sclk, copi, ncs
    );

    modport slave (
        input  start, addr, wdata,
        output busy, done, sclk, copi, ncs
    );
endinterface

// File: rtl/spi_write_controller.sv
// SPI mode-0 write initiator: sends {1'b1, addr[6:0], wdata[7:0]} MSB first.
// Every output comes straight from a flop.
module spi_write_controller #(
    parameter int unsigned CLK_DIV = 4
) (
    input logic        clk,
    input logic        rst_n,
    spi_write_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        GAP
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      shreg_q, shreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic             ncs_q, ncs_d;
    logic             sclk_q, sclk_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            bit_q   <= '0;
            ncs_q   <= 1'b1;
            sclk_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            ncs_q   <= ncs_d;
            sclk_q  <= sclk_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        ncs_d   = ncs_q;
        sclk_d  = sclk_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SETUP;
                    shreg_d = {1'b1, bus.addr, bus.wdata};
                    cnt_d   = '0;
                    bit_d   = 4'd15;
                    ncs_d   = 1'b0;
                    sclk_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end

            SETUP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = SHIFT;
                    sclk_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            SHIFT: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (sclk_q) begin
                        // Falling edge: present the next bit, except after the last one.
                        sclk_d = 1'b0;
                        if (bit_q != 4'd0) begin
                            shreg_d = {shreg_q[14:0], 1'b0};
                        end
                    end else if (bit_q == 4'd0) begin
                        state_d = GAP;
                        shreg_d = '0;
                        ncs_d   = 1'b1;
                        done_d  = 1'b1;
                    end else begin
                        bit_d  = bit_q - 4'd1;
                        sclk_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            GAP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // copi is the shift register MSB, which is cleared outside a frame.
    assign bus.copi = shreg_q[15];
    assign bus.ncs  = ncs_q;
    assign bus.sclk = sclk_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_spi_write_controller.sv
// Directed bench for spi_write_controller at CLK_DIV=4 and CLK_DIV=1.
module tb_spi_write_controller;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    spi_write_if bus4 ();
    spi_write_if bus1 ();

    spi_write_controller #(.CLK_DIV(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    spi_write_controller #(.CLK_DIV(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    // Wire monitor for the CLK_DIV=4 instance, sampled mid-cycle.
    logic [15:0] rx4 = '0;
    logic        sclk4_prev = 1'b0;
    int unsigned rises4 = 0, done4 = 0;
    int unsigned busy_run4 = 0, busy_len4 = 0, busy_ends4 = 0;
    int unsigned ncs_run4 = 0, ncs_len4 = 0;

    always @(negedge clk) begin
        if (bus4.sclk && !sclk4_prev) begin
            rx4 = {rx4[14:0], bus4.copi};
            rises4++;
        end
        sclk4_prev = bus4.sclk;
        if (bus4.done) done4++;
        if (bus4.busy) busy_run4++;
        else if (busy_run4 != 0) begin
            busy_len4 = busy_run4;
            busy_run4 = 0;
            busy_ends4++;
        end
        if (!bus4.ncs) ncs_run4++;
        else if (ncs_run4 != 0) begin
            ncs_len4 = ncs_run4;
            ncs_run4 = 0;
        end
    end

    // Wire monitor for the CLK_DIV=1 instance, logging per-frame data.
    logic [15:0] rx1 = '0;
    logic        sclk1_prev = 1'b0;
    logic        ncs1_prev  = 1'b1;
    logic [15:0] frm1 [0:3];
    int unsigned blen1 [0:3];
    int unsigned hlen1 [0:3];
    int unsigned fcnt1 = 0, rises1 = 0, done1 = 0;
    int unsigned brun1 = 0, bcnt1 = 0, hrun1 = 0, falls1 = 0;

    always @(negedge clk) begin
        if (bus1.sclk && !sclk1_prev) begin
            rx1 = {rx1[14:0], bus1.copi};
            rises1++;
        end
        sclk1_prev = bus1.sclk;
        if (bus1.done) done1++;
        if (bus1.ncs && !ncs1_prev) begin
            if (fcnt1 < 4) frm1[fcnt1[1:0]] = rx1;
            fcnt1++;
        end
        if (bus1.ncs) hrun1++;
        else if (ncs1_prev) begin
            if (falls1 < 4) hlen1[falls1[1:0]] = hrun1;
            falls1++;
            hrun1 = 0;
        end
        ncs1_prev = bus1.ncs;
        if (bus1.busy) brun1++;
        else if (brun1 != 0) begin
            if (bcnt1 < 4) blen1[bcnt1[1:0]] = brun1;
            bcnt1++;
            brun1 = 0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic send4(input logic [6:0] a, input logic [7:0] d);
        @(negedge clk);
        bus4.addr  = a;
        bus4.wdata = d;
        bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
    endtask

    task automatic wait_frame4(input int unsigned ends0, input string tag);
        int unsigned n = 0;
        while (busy_ends4 == ends0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check({tag, "_tmo"}, 32'(busy_ends4 != ends0), 32'd1);
        repeat (4) @(posedge clk);
    endtask

    int unsigned r0, d0, e0, n;

    initial begin
        bus4.start = 1'b0; bus4.addr = '0; bus4.wdata = '0;
        bus1.start = 1'b0; bus1.addr = '0; bus1.wdata = '0;
        repeat (3) @(negedge clk);
        check("rst4_ncs",  bus4.ncs,  1);
        check("rst4_sclk", bus4.sclk, 0);
        check("rst4_copi", bus4.copi, 0);
        check("rst4_busy", bus4.busy, 0);
        check("rst4_done", bus4.done, 0);
        check("rst1_ncs",  bus1.ncs,  1);
        check("rst1_sclk", bus1.sclk, 0);
        check("rst1_copi", bus1.copi, 0);
        check("rst1_busy", bus1.busy, 0);
        check("rst1_done", bus1.done, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Basic frame
        r0 = rises4; d0 = done4; e0 = busy_ends4;
        send4(7'h00, 8'hA5);
        wait_frame4(e0, "t1");
        check("t1_frame", 32'(rx4), 32'h80A5);
        check("t1_rises", rises4 - r0, 16);
        check("t1_busy",  busy_len4, 136);
        check("t1_ncs",   ncs_len4, 132);
        check("t1_done",  done4 - d0, 1);

        // start mid-frame is ignored
        r0 = rises4; d0 = done4; e0 = busy_ends4;
        send4(7'h12, 8'h34);
        repeat (18) @(negedge clk);
        bus4.addr = 7'h55; bus4.wdata = 8'h66; bus4.start = 1'b1;
        @(negedge clk);
        bus4.start = 1'b0;
        wait_frame4(e0, "t3");
        repeat (40) @(posedge clk);
        check("t3_frame",  32'(rx4), 32'h9234);
        check("t3_rises",  rises4 - r0, 16);
        check("t3_frames", busy_ends4 - e0, 1);
        check("t3_done",   done4 - d0, 1);

        // addr/wdata changed after acceptance
        r0 = rises4; e0 = busy_ends4;
        send4(7'h2B, 8'hC3);
        bus4.addr = 7'h7F; bus4.wdata = 8'h3C;
        wait_frame4(e0, "t4");
        check("t4_frame", 32'(rx4), 32'hABC3);
        check("t4_rises", rises4 - r0, 16);

        // Reset in the middle of a frame
        r0 = rises4; d0 = done4;
        send4(7'h05, 8'h5A);
        n = 0;
        while (rises4 - r0 < 5 && n < 400) begin
            @(posedge clk);
            n++;
        end
        check("t5_rise5", rises4 - r0, 5);
        #1 rst_n = 1'b0;
        #1;
        check("t5_ncs",  bus4.ncs,  1);
        check("t5_sclk", bus4.sclk, 0);
        check("t5_busy", bus4.busy, 0);
        repeat (10) @(negedge clk);
        check("t5_nodone", done4 - d0, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        r0 = rises4; d0 = done4; e0 = busy_ends4;
        send4(7'h33, 8'h99);
        wait_frame4(e0, "t5b");
        check("t5_frame", 32'(rx4), 32'hB399);
        check("t5_rises", rises4 - r0, 16);
        check("t5_busy",  busy_len4, 136);
        check("t5_done",  done4 - d0, 1);

        // Back-to-back frames at CLK_DIV=1 with start held high
        @(negedge clk);
        bus1.addr = 7'h11; bus1.wdata = 8'h22; bus1.start = 1'b1;
        n = 0;
        while (fcnt1 < 1 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1 bus1.addr = 7'h44; bus1.wdata = 8'h88;
        n = 0;
        while (fcnt1 < 2 && n < 200) begin
            @(posedge clk);
            n++;
        end
        #1 bus1.start = 1'b0;
        repeat (20) @(posedge clk);
        check("t6_nframes", fcnt1, 2);
        check("t6_frame0",  32'(frm1[0]), 32'h9122);
        check("t6_frame1",  32'(frm1[1]), 32'hC488);
        check("t6_rises",   rises1, 32);
        check("t6_busy0",   blen1[0], 34);
        check("t6_busy1",   blen1[1], 34);
        check("t6_ncs_hi",  hlen1[1], 2);
        check("t6_done",    done1, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
